// File: rtl/simt_pkg.sv
// Shared SIMT definitions: request-sequencer state encoding and default lane count.
package simt_pkg;

    localparam int SIMT_LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } req_state_t;

endpackage

// File: rtl/lane_priority_enc.sv
// Lowest-index-first priority encoder over a lane bit vector (purely combinational).
module lane_priority_enc #(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]         i_vec,
    output logic [$clog2(LANES)-1:0] o_idx,
    output logic                     o_any_set
);

    localparam int LW = $clog2(LANES);

    // Scan from the top lane down so the lowest set lane is the last to write o_idx.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_idx     = '0;
        o_any_set = |i_vec;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = LW'(i);
        end
    end

endmodule

// File: rtl/simt_request_unit.sv
// Captures per-lane data requests on instruction fetch and serialises them onto
// the shared dRen/dWen port, lowest lane first, with halt drain and a watchdog.
module simt_request_unit
    import simt_pkg::*;
#(
    parameter int LANES   = SIMT_LANES,
    parameter int TIMEOUT = 0
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     halt,
    input  logic                     iHit,
    input  logic                     dHit,
    input  logic [LANES-1:0]         r_req,
    input  logic [LANES-1:0]         w_req,
    input  logic [LANES-1:0]         lane_mask,
    output logic                     iRen,
    output logic                     dRen,
    output logic                     dWen,
    output logic [$clog2(LANES)-1:0] lane_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int LW = $clog2(LANES);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    req_state_t       r_st;
    logic [LANES-1:0] r_pend_r;
    logic [LANES-1:0] r_pend_w;
    logic [CW-1:0]    r_wdog;
    logic             r_err;
    logic             r_done;

    logic [LW-1:0]    w_sel;
    logic             w_any;
    logic             w_busy;
    logic             w_fire;
    logic             w_retire;
    logic             w_last;
    logic [LANES-1:0] w_clear_mask;
    logic [LANES-1:0] w_cap_r;
    logic [LANES-1:0] w_cap_w;
    logic             w_cap_both;

    lane_priority_enc #(.LANES(LANES)) u_enc (
        .i_vec     (r_pend_r | r_pend_w),
        .o_idx     (w_sel),
        .o_any_set (w_any)
    );

    assign w_busy       = (r_st == SERVE) || (r_st == DRAIN);
    // A concurrent dHit beats the watchdog, so the drop only fires without one.
    assign w_fire       = (TIMEOUT > 0) && w_busy && !dHit && (int'(r_wdog) == TIMEOUT - 1);
    assign w_retire     = w_busy && w_any && (dHit || w_fire);
    assign w_clear_mask = LANES'(1) << w_sel;
    assign w_last       = w_retire && (((r_pend_r | r_pend_w) & ~w_clear_mask) == '0);

    // Write wins over read when a lane asks for both; that case is flagged as an error.
    assign w_cap_w    = w_req & lane_mask;
    assign w_cap_r    = r_req & ~w_req & lane_mask;
    assign w_cap_both = |(r_req & w_req & lane_mask);

    // Sequencer state, pending vectors, sticky error and done pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_st     <= IDLE;
            r_pend_r <= '0;
            r_pend_w <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_done <= 1'b0;
            case (r_st)
                IDLE: begin
                    if (halt) begin
                        r_st <= HALTED;
                    end else if (iHit) begin
                        r_pend_w <= w_cap_w;
                        r_pend_r <= w_cap_r;
                        if (w_cap_both) r_err <= 1'b1;
                        if (|(w_cap_w | w_cap_r)) r_st <= SERVE;
                    end
                end
                SERVE, DRAIN: begin
                    if (w_retire) begin
                        r_pend_r <= r_pend_r & ~w_clear_mask;
                        r_pend_w <= r_pend_w & ~w_clear_mask;
                    end
                    if (w_fire) r_err <= 1'b1;
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_st   <= (r_st == DRAIN || halt) ? HALTED : IDLE;
                    end else if (halt) begin
                        r_st <= DRAIN;
                    end
                end
                default: ; // HALTED holds until reset
            endcase
        end
    end

    // Per-request watchdog: counts busy cycles without dHit, cleared on completion or drop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wdog <= '0;
        end else if (TIMEOUT == 0 || !w_busy || dHit || w_fire) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign iRen     = (r_st == IDLE);
    assign busy     = w_busy;
    assign lane_sel = w_sel;
    assign dRen     = w_busy & r_pend_r[w_sel];
    assign dWen     = w_busy & r_pend_w[w_sel];
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_simt_request_unit.sv
// Directed bench for simt_request_unit: two instances (watchdog off / TIMEOUT=8)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_simt_request_unit;
    import simt_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       halt = 1'b0, iHit = 1'b0, dHit = 1'b0;
    logic [3:0] r_req = '0, w_req = '0, lane_mask = '0;

    logic       iren0, dren0, dwen0, busy0, done0, err0;
    logic [1:0] sel0;
    logic       iren8, dren8, dwen8, busy8, done8, err8;
    logic [1:0] sel8;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    simt_request_unit #(.LANES(4), .TIMEOUT(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .halt(halt), .iHit(iHit), .dHit(dHit),
        .r_req(r_req), .w_req(w_req), .lane_mask(lane_mask),
        .iRen(iren0), .dRen(dren0), .dWen(dwen0), .lane_sel(sel0),
        .busy(busy0), .done(done0), .err(err0)
    );

    simt_request_unit #(.LANES(4), .TIMEOUT(8)) dut8 (
        .CLK(CLK), .nRST(nRST), .halt(halt), .iHit(iHit), .dHit(dHit),
        .r_req(r_req), .w_req(w_req), .lane_mask(lane_mask),
        .iRen(iren8), .dRen(dren8), .dWen(dwen8), .lane_sel(sel8),
        .busy(busy8), .done(done8), .err(err8)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        req_state_t  st;
        logic [3:0]  pr;
        logic [3:0]  pw;
        logic [31:0] wd;
        logic        err;
        logic        done;
    } mdl_t;

    mdl_t m0, m8;

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic mdl_t reset_mdl();
        mdl_t m;
        m    = '0;
        m.st = IDLE;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, logic h, logic ih, logic dh,
                                  logic [3:0] rq, logic [3:0] wq, logic [3:0] mk, int to);
        mdl_t n;
        int   lane;
        bit   fire;
        n      = m;
        n.done = 1'b0;
        if (m.st == IDLE) begin
            if (h) n.st = HALTED;
            else if (ih) begin
                n.pw = wq & mk;
                n.pr = rq & ~wq & mk;
                if ((rq & wq & mk) != 0) n.err = 1'b1;
                if ((n.pr | n.pw) != 0) n.st = SERVE;
            end
        end else if (m.st == SERVE || m.st == DRAIN) begin
            lane = lowest(m.pr | m.pw);
            fire = (to > 0) && !dh && (m.wd == 32'(to - 1));
            if (dh || fire) begin
                n.pr[lane] = 1'b0;
                n.pw[lane] = 1'b0;
                n.wd       = 0;
                if (fire) n.err = 1'b1;
                if ((n.pr | n.pw) == 0) begin
                    n.done = 1'b1;
                    n.st   = (m.st == DRAIN || h) ? HALTED : IDLE;
                end else if (h) n.st = DRAIN;
            end else begin
                if (to > 0) n.wd = m.wd + 1;
                if (h) n.st = DRAIN;
            end
        end
        return n;
    endfunction

    // Packed as {iRen, dRen, dWen, lane_sel[1:0], busy, done, err}.
    function automatic logic [7:0] expect_out(mdl_t m);
        logic       b;
        logic [1:0] s;
        b = (m.st == SERVE) || (m.st == DRAIN);
        s = 2'(lowest(m.pr | m.pw));
        return {m.st == IDLE, b & m.pr[s], b & m.pw[s], s, b, m.done, m.err};
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m0 <= reset_mdl();
            m8 <= reset_mdl();
        end else begin
            m0 <= step(m0, halt, iHit, dHit, r_req, w_req, lane_mask, 0);
            m8 <= step(m8, halt, iHit, dHit, r_req, w_req, lane_mask, 8);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        if (nRST) begin
            check("model_dut0", {24'd0, iren0, dren0, dwen0, sel0, busy0, done0, err0}, {24'd0, expect_out(m0)});
            check("model_dut8", {24'd0, iren8, dren8, dwen8, sel8, busy8, done8, err8}, {24'd0, expect_out(m8)});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(logic h, logic ih, logic dh, logic [3:0] rq, logic [3:0] wq, logic [3:0] mk);
        halt = h; iHit = ih; dHit = dh; r_req = rq; w_req = wq; lane_mask = mk;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        halt = 0; iHit = 0; dHit = 0; r_req = '0; w_req = '0; lane_mask = '0;
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        // Test 1: reset values, then two reads serviced lowest lane first.
        do_reset();
        check("rst_iren", iren0, 1); check("rst_busy", busy0, 0);
        check("rst_dren", dren0, 0); check("rst_sel", sel0, 0);
        check("rst_err8", err8, 0);
        cyc(0, 1, 0, 4'b0101, 4'b0000, 4'b1111);
        check("t1_dren", dren0, 1); check("t1_sel0", sel0, 0); check("t1_iren", iren0, 0);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t1_sel2", sel0, 2); check("t1_dren2", dren0, 1);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t1_done", done0, 1); check("t1_iren_back", iren0, 1);
        cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
        check("t1_done_pulse", done0, 0);

        // Test 2: masked lane 0, lane 1 read+write collapses to a write and flags err.
        cyc(0, 1, 0, 4'b0011, 4'b0010, 4'b1110);
        check("t2_sel", sel0, 1); check("t2_dwen", dwen0, 1);
        check("t2_dren", dren0, 0); check("t2_err", err0, 1);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t2_done", done0, 1); check("t2_err_sticky", err0, 1);

        // Test 3: halt during SERVE drains lanes 1 and 3, then HALTED ignores iHit.
        do_reset();
        cyc(0, 1, 0, 4'b1010, 4'b0000, 4'b1111);
        cyc(1, 0, 0, 4'b0000, 4'b0000, 4'b1111);
        check("t3_busy", busy0, 1); check("t3_iren", iren0, 0); check("t3_sel1", sel0, 1);
        cyc(1, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t3_sel3", sel0, 3); check("t3_iren_drain", iren0, 0);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t3_done", done0, 1); check("t3_halt_busy", busy0, 0); check("t3_halt_iren", iren0, 0);
        cyc(0, 1, 0, 4'b1111, 4'b0000, 4'b1111);
        check("t3_ign_dren", dren0, 0); check("t3_ign_busy", busy0, 0);
        cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);

        // Test 4: watchdog drops lane 2 after 8 silent cycles; dHit on cycle 8 wins.
        do_reset();
        cyc(0, 1, 0, 4'b0100, 4'b0000, 4'b1111);
        repeat (7) cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
        check("t4_still_busy", busy8, 1); check("t4_sel", sel8, 2); check("t4_no_err_yet", err8, 0);
        cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
        check("t4_drop_done", done8, 1); check("t4_drop_err", err8, 1); check("t4_drop_iren", iren8, 1);
        check("t4_nowdog_busy", busy0, 1);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t4_nowdog_done", done0, 1); check("t4_nowdog_err", err0, 0);
        do_reset();
        cyc(0, 1, 0, 4'b0100, 4'b0000, 4'b1111);
        repeat (7) cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t4b_done", done8, 1); check("t4b_err", err8, 0);

        // Test 5: halt and iHit together in IDLE go straight to HALTED.
        do_reset();
        cyc(1, 1, 0, 4'b0000, 4'b1111, 4'b1111);
        check("t5_iren", iren0, 0); check("t5_busy", busy0, 0); check("t5_dwen", dwen0, 0);
        cyc(0, 1, 0, 4'b0000, 4'b1111, 4'b1111);
        check("t5_dwen_later", dwen0, 0);

        // Test 6: asynchronous reset mid-SERVE, then a fresh capture.
        do_reset();
        cyc(0, 1, 0, 4'b0111, 4'b0000, 4'b1111);
        cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);
        check("t6_pre_busy", busy0, 1);
        #2 nRST = 1'b0;
        #1;
        check("t6_async_iren", iren0, 1); check("t6_async_busy", busy0, 0);
        check("t6_async_dren", dren0, 0); check("t6_async_sel", sel8, 0);
        @(negedge CLK);
        nRST = 1'b1;
        cyc(0, 1, 0, 4'b1000, 4'b0000, 4'b1111);
        check("t6_fresh_sel", sel0, 3); check("t6_fresh_dren", dren0, 1);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 4'b1111);
        check("t6_fresh_done", done0, 1);
        cyc(0, 0, 0, 4'b0000, 4'b0000, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
